// File: rtl/frame_sequencer_if.sv
// Bus bundle between frame_sequencer, its frame-buffer memory and the pixel pipeline.
// Memory side is a read strobe with fixed 1-cycle data return; pixel side is a valid-only stream.
interface frame_sequencer_if #(
  parameter int ADDR_W  = 20,
  parameter int DIM_W   = 12,
  parameter int PIXEL_W = 24
);
  // Handshake: mem_data is valid exactly one cycle after mem_rd. en marks a valid pixel on
  // data/x/y/hsync/vsync; there is no ready. pause is the stall request: while it is high no new
  // read is issued, and a read issued the cycle before pause rose is still delivered (1-cycle skid).
  logic               mem_rd;
  logic [ADDR_W-1:0]  mem_addr;
  logic [PIXEL_W-1:0] mem_data;
  logic               pause;
  logic               en;
  logic [PIXEL_W-1:0] data;
  logic               hsync;
  logic               vsync;
  logic [DIM_W-1:0]   x;
  logic [DIM_W-1:0]   y;

  modport master (
    output mem_rd, mem_addr, en, data, hsync, vsync, x, y,
    input  mem_data, pause
  );

  modport slave (
    input  mem_rd, mem_addr, en, data, hsync, vsync, x, y,
    output mem_data, pause
  );
endinterface

// File: rtl/frame_sequencer.sv
// Streams one frame from a byte-addressed frame buffer (rows padded to 4 bytes) to the pixel pipeline.
// Define SEQ_BOTTOM_UP_EN for bottom-up (BMP order) row storage; default reads rows in stored order.
module frame_sequencer #(
  parameter int ADDR_W  = 20,
  parameter int DIM_W   = 12,
  parameter int PIXEL_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic [ADDR_W-1:0] base_addr,
  output logic              busy,
  output logic              done,
  output logic [2:0]        dbg_state,
  frame_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_PREFETCH = 3'd1,
    S_RUN      = 3'd2,
    S_DRAIN    = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  state_t state, state_nx;

  logic [DIM_W-1:0]  w_q, h_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] col_off;
  logic [DIM_W-1:0]  col, row;

  logic              en_q, hs_q, vs_q;
  logic [DIM_W-1:0]  x_q, y_q;

  logic [DIM_W+1:0]  width_x3;
  logic [DIM_W+1:0]  width_x3_up;
  logic [ADDR_W-1:0] stride_c;
  logic              zero_dim;
  logic              issue;
  logic              last_col, last_row;

`ifdef SEQ_BOTTOM_UP_EN
  logic [DIM_W-1:0]  pf_cnt;
`endif

  // Stride rounds 3*width up to a multiple of 4; the sum cannot overflow DIM_W+2 bits.
  always_comb begin
    width_x3    = ({2'b00, width} << 1) + {2'b00, width};
    width_x3_up = width_x3 + (DIM_W + 2)'(3);
    stride_c    = ADDR_W'({width_x3_up[DIM_W+1:2], 2'b00});
  end

  assign zero_dim = (width == '0) || (height == '0);
  assign issue    = (state == S_RUN) && !bus.pause;
  assign last_col = (col == w_q - DIM_W'(1));
  assign last_row = (row == h_q - DIM_W'(1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE: begin
        // A zero-sized frame passes through DRAIN so done lands two cycles after start.
        if (start) begin
          if (zero_dim) begin
            state_nx = S_DRAIN;
          end else begin
`ifdef SEQ_BOTTOM_UP_EN
            state_nx = (height > DIM_W'(1)) ? S_PREFETCH : S_RUN;
`else
            state_nx = S_RUN;
`endif
          end
        end
      end
      S_PREFETCH: begin
`ifdef SEQ_BOTTOM_UP_EN
        if (pf_cnt == DIM_W'(1)) state_nx = S_RUN;
`else
        state_nx = S_IDLE;
`endif
      end
      S_RUN: begin
        if (issue && last_col && last_row) state_nx = S_DRAIN;
      end
      S_DRAIN: state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      w_q      <= '0;
      h_q      <= '0;
      stride_q <= '0;
      row_base <= '0;
      col_off  <= '0;
      col      <= '0;
      row      <= '0;
`ifdef SEQ_BOTTOM_UP_EN
      pf_cnt   <= '0;
`endif
    end else begin
      if (state == S_IDLE && start) begin
        w_q      <= width;
        h_q      <= height;
        stride_q <= stride_c;
        row_base <= base_addr;
        col_off  <= '0;
        col      <= '0;
        row      <= '0;
`ifdef SEQ_BOTTOM_UP_EN
        pf_cnt   <= height - DIM_W'(1);
`endif
      end

`ifdef SEQ_BOTTOM_UP_EN
      // Walk row_base to the last stored row, which holds the top image row.
      if (state == S_PREFETCH) begin
        row_base <= row_base + stride_q;
        pf_cnt   <= pf_cnt - DIM_W'(1);
      end
`endif

      if (issue) begin
        if (last_col) begin
          col     <= '0;
          col_off <= '0;
          row     <= row + DIM_W'(1);
`ifdef SEQ_BOTTOM_UP_EN
          row_base <= row_base - stride_q;
`else
          row_base <= row_base + stride_q;
`endif
        end else begin
          col     <= col + DIM_W'(1);
          col_off <= col_off + ADDR_W'(3);
        end
      end
    end
  end

  // Output stage: tags travel one cycle behind the read so they line up with mem_data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      en_q <= 1'b0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      x_q  <= '0;
      y_q  <= '0;
    end else begin
      en_q <= issue;
      hs_q <= issue && (col == '0);
      vs_q <= issue && (col == '0) && (row == '0);
      x_q  <= issue ? col : '0;
      y_q  <= issue ? row : '0;
    end
  end

  assign bus.mem_rd   = issue;
  assign bus.mem_addr = issue ? (row_base + col_off) : '0;
  assign bus.en       = en_q;
  assign bus.data     = en_q ? bus.mem_data : '0;
  assign bus.hsync    = hs_q;
  assign bus.vsync    = vs_q;
  assign bus.x        = x_q;
  assign bus.y        = y_q;

  assign busy      = (state == S_PREFETCH) || (state == S_RUN) || (state == S_DRAIN);
  assign done      = (state == S_DONE);
  assign dbg_state = state;

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: table of frames plus random frames against a frame-level model,
// and hand-written reset-abort sequence.
module tb_frame_sequencer;
  localparam int ADDR_W  = 20;
  localparam int DIM_W   = 12;
  localparam int PIXEL_W = 24;
  localparam int PIX_W   = PIXEL_W + 2 * DIM_W + 2;

`ifdef SEQ_BOTTOM_UP_EN
  localparam bit BU = 1'b1;
`else
  localparam bit BU = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  width = '0;
  logic [DIM_W-1:0]  height = '0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic              busy, done;
  logic [2:0]        dbg_state;

  frame_sequencer_if #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .PIXEL_W(PIXEL_W)) bus ();

  frame_sequencer #(.ADDR_W(ADDR_W), .DIM_W(DIM_W), .PIXEL_W(PIXEL_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .width     (width),
    .height    (height),
    .base_addr (base_addr),
    .busy      (busy),
    .done      (done),
    .dbg_state (dbg_state),
    .bus       (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  function automatic logic [7:0] mbyte(input logic [ADDR_W-1:0] a);
    return a[7:0] ^ {a[11:8], a[15:12]} ^ {4'h5, a[19:16]};
  endfunction

  function automatic logic [PIXEL_W-1:0] mword(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] a1, a2;
    a1 = a + 20'd1;
    a2 = a + 20'd2;
    return {mbyte(a2), mbyte(a1), mbyte(a)};
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n)        bus.mem_data <= '0;
    else if (bus.mem_rd) bus.mem_data <= mword(bus.mem_addr);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [PIX_W-1:0]  exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: pixel order, padded stride and wrap come straight from the frame geometry.
  task automatic build_model(input int w, input int h, input logic [ADDR_W-1:0] base);
    int stride, stored;
    logic [ADDR_W-1:0] a;
    exp_addr_q.delete();
    exp_q.delete();
    stride = ((3 * w + 3) / 4) * 4;
    for (int r = 0; r < h; r++) begin
      stored = BU ? (h - 1 - r) : r;
      for (int c = 0; c < w; c++) begin
        a = base + ADDR_W'(stored * stride) + ADDR_W'(3 * c);
        exp_addr_q.push_back(a);
        exp_q.push_back({mword(a), DIM_W'(c), DIM_W'(r), (c == 0), (c == 0 && r == 0)});
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_frame(input int w, input int h, input logic [ADDR_W-1:0] base,
                           input int p_lo, input int p_hi, input int repulse, input int exp_done_tbl);
    int n, first_rd, rd_idx, last_rd_c, done_c;
    bit prev_rd, exp_rd, exp_done, pause_c;
    logic [ADDR_W-1:0] a_exp;
    logic [PIX_W-1:0]  p_exp;
    build_model(w, h, base);
    n         = w * h;
    first_rd  = 1 + ((BU && h > 1) ? h - 1 : 0);
    rd_idx    = 0;
    last_rd_c = -100;
    done_c    = -1;
    prev_rd   = 1'b0;
    for (int c = 0; c < 400 && done_c < 0; c++) begin
      @(posedge clk);
      #1;
      pause_c = (c >= p_lo) && (c <= p_hi);
      bus.pause = pause_c;
      if (c == 0) begin
        width = DIM_W'(w); height = DIM_W'(h); base_addr = base; start = 1'b1;
      end else if (c == repulse) begin
        width = DIM_W'($urandom_range(1, 9)); height = DIM_W'($urandom_range(1, 9));
        base_addr = ADDR_W'($urandom); start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      exp_rd = (n > 0) && (c >= first_rd) && (rd_idx < n) && !pause_c;
      chk("mem_rd", bus.mem_rd, exp_rd);
      if (bus.mem_rd && exp_addr_q.size() > 0) begin
        a_exp = exp_addr_q.pop_front();
        chk("mem_addr", bus.mem_addr, a_exp);
      end
      if (exp_rd) begin
        rd_idx++;
        last_rd_c = c;
      end
      chk("en", bus.en, prev_rd);
      if (bus.en && exp_q.size() > 0) begin
        p_exp = exp_q.pop_front();
        chk("pixel", {bus.data, bus.x, bus.y, bus.hsync, bus.vsync}, p_exp);
      end
      prev_rd  = exp_rd;
      exp_done = (n == 0) ? (c == 2) : (rd_idx == n && c == last_rd_c + 2);
      chk("done", done, exp_done);
      chk("busy", busy, (c >= 1) && !exp_done);
      if (done) done_c = c;
    end
    start = 1'b0;
    bus.pause = 1'b0;
    if (done_c < 0) begin
      errors++;
      checks++;
      $display("FAIL done_timeout: got no done expected done within 400 cycles");
    end
    if (exp_done_tbl >= 0) chk("done_cycle", 64'(done_c), 64'(exp_done_tbl));
    chk("pixels_left", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- table of frames ----------------
  typedef struct {
    int                w;
    int                h;
    logic [ADDR_W-1:0] base;
    int                p_lo;
    int                p_hi;
    int                repulse;
    int                exp_done;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int extra;
    bus.pause = 1'b0;
    vecs[0] = '{3, 2, 20'h00000, -1, -1, -1, 8};
    vecs[1] = '{4, 1, 20'h00100,  3,  5, -1, 9};
    vecs[2] = '{0, 5, 20'h00000, -1, -1, -1, 2};
    vecs[3] = '{5, 0, 20'h00040, -1, -1, -1, 2};
    vecs[4] = '{5, 2, 20'hFFFF0, -1, -1, -1, 12};
    vecs[5] = '{1, 1, 20'h00100, -1, -1, -1, 3};
    vecs[6] = '{3, 2, 20'h00040, -1, -1,  3, 8};
    vecs[7] = '{2, 3, 20'h01000,  4,  4, -1, 9};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ctrl", {bus.mem_rd, bus.en, bus.hsync, bus.vsync, busy, done}, 6'd0);
    chk("rst_bus", {bus.mem_addr, bus.x, bus.y}, 44'd0);
    chk("rst_data", bus.data, 24'd0);
    chk("rst_state", dbg_state, 3'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      extra = (BU && vecs[i].w > 0 && vecs[i].h > 1) ? vecs[i].h - 1 : 0;
      run_frame(vecs[i].w, vecs[i].h, vecs[i].base, vecs[i].p_lo, vecs[i].p_hi,
                vecs[i].repulse, vecs[i].exp_done + extra);
    end

    // Random frames against the model
    for (int i = 0; i < 12; i++) begin
      int lo;
      lo = $urandom_range(0, 10);
      run_frame($urandom_range(0, 6), $urandom_range(0, 4), ADDR_W'($urandom),
                lo, lo + $urandom_range(0, 3), -1, -1);
    end

    // Reset mid-frame: outputs clear asynchronously and no done follows
    @(posedge clk);
    #1;
    width = 12'd4; height = 12'd3; base_addr = 20'h00200; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("abort_ctrl", {bus.mem_rd, bus.en, bus.hsync, bus.vsync, busy, done}, 6'd0);
    chk("abort_bus", {bus.mem_addr, bus.x, bus.y}, 44'd0);
    chk("abort_data", bus.data, 24'd0);
    chk("abort_state", dbg_state, 3'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("abort_no_done", {done, busy}, 2'd0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    run_frame(3, 2, 20'h00000, -1, -1, -1, BU ? 9 : 8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
